// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - VGA raster timing bundle (frame_cnt present with VGA_SYNC_FRAME_CNT_EN)
interface vga_sync_gen_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt;

    modport master (
        output hsync, vsync, video_on, pixel_x, pixel_y, frame_start, frame_cnt
    );

    modport slave (
        input hsync, vsync, video_on, pixel_x, pixel_y, frame_start, frame_cnt
    );
`else
    modport master (
        output hsync, vsync, video_on, pixel_x, pixel_y, frame_start
    );

    modport slave (
        input hsync, vsync, video_on, pixel_x, pixel_y, frame_start
    );
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA raster timing generator; optional frame counter via VGA_SYNC_FRAME_CNT_EN
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic           clk_25mhz,
    input  logic           rst_n,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       frame_start_q, frame_start_d;

    // Next raster position: h wraps every line, v advances only on the h wrap
    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = 10'd0;
            if (vcnt_q == V_LAST) begin
                vcnt_d = 10'd0;
            end else begin
                vcnt_d = vcnt_q + 10'd1;
            end
        end
    end

    // Flags decoded from the next position so they register alongside the counters
    always_comb begin
        hsync_d       = 1'b1;
        vsync_d       = 1'b1;
        video_on_d    = 1'b0;
        frame_start_d = 1'b0;
        if (hcnt_d >= HS_FIRST && hcnt_d <= HS_LAST) begin
            hsync_d = 1'b0;
        end
        if (vcnt_d >= VS_FIRST && vcnt_d <= VS_LAST) begin
            vsync_d = 1'b0;
        end
        if (hcnt_d < H_VIS && vcnt_d < V_VIS) begin
            video_on_d = 1'b1;
        end
        if (hcnt_d == 10'd0 && vcnt_d == 10'd0) begin
            frame_start_d = 1'b1;
        end
    end

    // Raster state; reset parks on the last back-porch position so (0,0) follows release
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q        <= H_LAST;
            vcnt_q        <= V_LAST;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pixel_x     = hcnt_q;
    assign vga.pixel_y     = vcnt_q;
    assign vga.frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Count advances together with the strobe, so the first frame after reset reads 1
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Frame counter register
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen (default and reduced raster)
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        int n;
        int x;
        int y;
        bit hs;
        bit vs;
        bit von;
        bit fs;
    } vec_t;

    // Reduced raster for instance B: 16 x 10 = 160 cycles per frame
    localparam int B_HA = 8, B_HF = 2, B_HS = 3, B_HB = 3;
    localparam int B_VA = 5, B_VF = 1, B_VS = 2, B_VB = 2;
    localparam int B_FT = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);

    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;

    int n_a = -1;
    int n_b = -1;
    int checks = 0;
    int fails = 0;

    initial forever #5 clk = ~clk;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();

    vga_sync_gen u_a (
        .clk_25mhz (clk),
        .rst_n     (rst_n_a),
        .vga       (if_a)
    );

    vga_sync_gen #(
        .H_ACTIVE (B_HA), .H_FP (B_HF), .H_SYNC (B_HS), .H_BP (B_HB),
        .V_ACTIVE (B_VA), .V_FP (B_VF), .V_SYNC (B_VS), .V_BP (B_VB)
    ) u_b (
        .clk_25mhz (clk),
        .rst_n     (rst_n_b),
        .vga       (if_b)
    );

    function automatic obs_t model(int n, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb);
        obs_t o;
        int ht, vt, p, x, y;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (n < 0) begin
            o.x = 10'(ht - 1);
            o.y = 10'(vt - 1);
            o.hs = 1'b1;
            o.vs = 1'b1;
            o.von = 1'b0;
            o.fs = 1'b0;
            o.fc = 8'd0;
        end else begin
            p = n % (ht * vt);
            x = p % ht;
            y = p / ht;
            o.x = 10'(x);
            o.y = 10'(y);
            o.hs = !(x >= ha + hf && x < ha + hf + hsw);
            o.vs = !(y >= va + vf && y < va + vf + vsw);
            o.von = (x < ha) && (y < va);
            o.fs = (p == 0);
            o.fc = 8'((n / (ht * vt) + 1) % 256);
        end
`ifndef VGA_SYNC_FRAME_CNT_EN
        o.fc = 8'd0;
`endif
        return o;
    endfunction

    function automatic obs_t model_a(int n);
        return model(n, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t model_b(int n);
        return model(n, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB);
    endfunction

    function automatic obs_t get_a();
        obs_t o;
        o.x = if_a.pixel_x;
        o.y = if_a.pixel_y;
        o.hs = if_a.hsync;
        o.vs = if_a.vsync;
        o.von = if_a.video_on;
        o.fs = if_a.frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
        o.fc = if_a.frame_cnt;
`else
        o.fc = 8'd0;
`endif
        return o;
    endfunction

    function automatic obs_t get_b();
        obs_t o;
        o.x = if_b.pixel_x;
        o.y = if_b.pixel_y;
        o.hs = if_b.hsync;
        o.vs = if_b.vsync;
        o.von = if_b.video_on;
        o.fs = if_b.frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
        o.fc = if_b.frame_cnt;
`else
        o.fc = 8'd0;
`endif
        return o;
    endfunction

    task automatic check_obs(string name, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b von=%b fs=%b fc=%0d",
                     name, act.x, act.y, act.hs, act.vs, act.von, act.fs, act.fc,
                     exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.fs, exp.fc);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycles since reset release per instance; -1 while in reset
    initial forever begin
        @(posedge clk);
        n_a = rst_n_a ? n_a + 1 : -1;
        n_b = rst_n_b ? n_b + 1 : -1;
    end

    // Continuous comparison of both instances against the reference model
    initial forever begin
        @(negedge clk);
        check_obs("monitor_a", get_a(), model_a(rst_n_a ? n_a : -1));
        check_obs("monitor_b", get_b(), model_b(rst_n_b ? n_b : -1));
    end

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_obs("reset_a", get_a(), model_a(-1));
        check_obs("reset_b", get_b(), model_b(-1));
        @(posedge clk);
        #2;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        fork
            // Boundary vectors on the full-size raster
            begin
                vec_t tbl[12];
                int g;
                obs_t act;
                tbl[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
                tbl[1]  = '{1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
                tbl[2]  = '{639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0};
                tbl[3]  = '{640,  640, 0, 1'b1, 1'b1, 1'b0, 1'b0};
                tbl[4]  = '{655,  655, 0, 1'b1, 1'b1, 1'b0, 1'b0};
                tbl[5]  = '{656,  656, 0, 1'b0, 1'b1, 1'b0, 1'b0};
                tbl[6]  = '{751,  751, 0, 1'b0, 1'b1, 1'b0, 1'b0};
                tbl[7]  = '{752,  752, 0, 1'b1, 1'b1, 1'b0, 1'b0};
                tbl[8]  = '{799,  799, 0, 1'b1, 1'b1, 1'b0, 1'b0};
                tbl[9]  = '{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b0};
                tbl[10] = '{1439, 639, 1, 1'b1, 1'b1, 1'b1, 1'b0};
                tbl[11] = '{1440, 640, 1, 1'b1, 1'b1, 1'b0, 1'b0};
                for (int i = 0; i < 12; i++) begin
                    g = 0;
                    while (n_a < tbl[i].n && g < 5000) begin
                        @(negedge clk);
                        g++;
                    end
                    check_int("vec_pos", n_a, tbl[i].n);
                    act = get_a();
                    checks++;
                    if (int'(act.x) != tbl[i].x || int'(act.y) != tbl[i].y ||
                        act.hs != tbl[i].hs || act.vs != tbl[i].vs ||
                        act.von != tbl[i].von || act.fs != tbl[i].fs) begin
                        fails++;
                        $display("FAIL vec[%0d]: got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b fs=%b",
                                 i, act.x, act.y, act.hs, act.vs, act.von, act.fs,
                                 tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].von, tbl[i].fs);
                    end
                end
            end
            // Line 0 pulse widths on the full-size raster
            begin
                int g, hs_low, von_hi, first_low;
                g = 0;
                hs_low = 0;
                von_hi = 0;
                first_low = -1;
                while (n_a < 0 && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                for (int i = 0; i < 800; i++) begin
                    if (!if_a.hsync) begin
                        hs_low++;
                        if (first_low < 0) first_low = int'(if_a.pixel_x);
                    end
                    if (if_a.video_on) von_hi++;
                    @(negedge clk);
                end
                check_int("line0_hsync_low_cycles", hs_low, 96);
                check_int("line0_hsync_first_x", first_low, 656);
                check_int("line0_video_on_cycles", von_hi, 640);
            end
            // Random mid-frame resets, then frame period and counter on the reduced raster
            begin
                int g, target, cnt;
                for (int r = 0; r < 3; r++) begin
                    target = n_b + int'($urandom_range(1, 400));
                    g = 0;
                    while (n_b < target && g < 1000) begin
                        @(posedge clk);
                        #2;
                        g++;
                    end
                    rst_n_b = 1'b0;
                    #1;
                    check_obs("async_reset_b", get_b(), model_b(-1));
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #1;
                    check_obs("held_reset_b", get_b(), model_b(-1));
                    #1;
                    rst_n_b = 1'b1;
                    @(negedge clk);
                    check_obs("released_no_edge_b", get_b(), model_b(-1));
                    @(negedge clk);
                    check_obs("first_edge_b", get_b(), model_b(0));
                end
                for (int f = 0; f < 257; f++) begin
                    cnt = 0;
                    do begin
                        @(negedge clk);
                        cnt++;
                    end while (!if_b.frame_start && cnt < 1000);
                    check_int("frame_period_b", cnt, B_FT);
`ifdef VGA_SYNC_FRAME_CNT_EN
                    check_int("frame_cnt_b", int'(if_b.frame_cnt), (f + 2) % 256);
`endif
                end
                @(negedge clk);
                check_int("strobe_width_b", int'(if_b.frame_start), 0);
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
